// File: rtl/legup_system_jtag_byte_rx_fifo_if.sv
// Byte stream bundle between the JTAG timing adapter, the rx FIFO and its consumer.
// JTAG_BYTE_FIFO_STATS_EN adds the drop_count signal.
interface legup_system_jtag_byte_rx_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;
    logic [ADDR_WIDTH:0]   fill_level;
    logic                  overflow;
    logic                  clear_overflow;
`ifdef JTAG_BYTE_FIFO_STATS_EN
    logic [15:0]           drop_count;
`endif

    modport master (
        output in_valid, in_data, out_ready, clear_overflow,
        input  in_ready, out_valid, out_data, fill_level, overflow
`ifdef JTAG_BYTE_FIFO_STATS_EN
        , input drop_count
`endif
    );

    modport slave (
        input  in_valid, in_data, out_ready, clear_overflow,
        output in_ready, out_valid, out_data, fill_level, overflow
`ifdef JTAG_BYTE_FIFO_STATS_EN
        , output drop_count
`endif
    );
endinterface

// File: rtl/legup_system_jtag_byte_rx_fifo.sv
// Elastic byte FIFO behind the JTAG bridge; the source cannot stall, so overflowed bytes are dropped
// and flagged. JTAG_BYTE_FIFO_STATS_EN adds a saturating drop counter.
module legup_system_jtag_byte_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic clk,
    input  logic reset,
    legup_system_jtag_byte_rx_fifo_if.slave bus
);
    localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE    = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  full;
    logic                  out_valid;
    logic                  push;
    logic                  pop;
    logic                  drop;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign full      = (count == FULL_COUNT);
    assign out_valid = (count != '0);
    assign pop       = out_valid & bus.out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    assign push      = bus.in_valid & (~full | pop);
    assign drop      = bus.in_valid & full & ~pop;

    assign bus.in_ready   = ~full;
    assign bus.out_valid  = out_valid;
    assign bus.out_data   = out_valid ? mem[rd_ptr] : '0;
    assign bus.fill_level = count;
    assign bus.overflow   = overflow;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop) begin
                overflow <= 1'b1;
            end else if (bus.clear_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef JTAG_BYTE_FIFO_STATS_EN
    logic [15:0] drop_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count <= '0;
        end else if (bus.clear_overflow) begin
            drop_count <= drop ? 16'd1 : 16'd0;
        end else if (drop) begin
            drop_count <= sat_inc(drop_count);
        end
    end

    assign bus.drop_count = drop_count;
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset && drop) begin
            $display("jtag byte rx fifo: dropped byte 0x%02h", bus.in_data);
        end
    end
`endif
endmodule

// File: tb/tb_legup_system_jtag_byte_rx_fifo.sv
// Directed bench for the JTAG byte rx FIFO: reset, pass-through, fill/wrap, overflow, full-with-pop,
// clear/drop collision and mid-stream reset.
module tb_legup_system_jtag_byte_rx_fifo;
    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_err = 0;

    legup_system_jtag_byte_rx_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

    legup_system_jtag_byte_rx_fifo #(.DATA_WIDTH(8), .DEPTH(16), .ADDR_WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_16(input int base);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(base + i);
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset              = 1'b1;
        bus.in_valid       = 1'b1;
        bus.in_data        = 8'hFF;
        bus.out_ready      = 1'b0;
        bus.clear_overflow = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_fill", 32'(bus.fill_level), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_overflow", 32'(bus.overflow), 0);
        chk("rst_out_data", 32'(bus.out_data), 0);
`ifdef JTAG_BYTE_FIFO_STATS_EN
        chk("rst_drop_count", 32'(bus.drop_count), 0);
`endif
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        chk("idle_fill", 32'(bus.fill_level), 0);

        // Pass-through
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'hA5;
        tick();
        bus.in_valid  = 1'b0;
        chk("pt_valid", 32'(bus.out_valid), 1);
        chk("pt_data", 32'(bus.out_data), 'hA5);
        chk("pt_fill1", 32'(bus.fill_level), 1);
        tick();
        chk("pt_valid_after", 32'(bus.out_valid), 0);
        chk("pt_fill0", 32'(bus.fill_level), 0);
        chk("pt_data_zero", 32'(bus.out_data), 0);

        // Fill and drain three times; start pointer is 1 so both pointers wrap
        for (int r = 0; r < 3; r++) begin
            fill_16(0);
            chk("fw_fill", 32'(bus.fill_level), 16);
            chk("fw_in_ready", 32'(bus.in_ready), 0);
            chk("fw_overflow", 32'(bus.overflow), 0);
            bus.out_ready = 1'b1;
            for (int i = 0; i < 16; i++) begin
                chk("fw_drain_valid", 32'(bus.out_valid), 1);
                chk("fw_drain_data", 32'(bus.out_data), 32'(i));
                tick();
            end
            chk("fw_empty", 32'(bus.fill_level), 0);
            chk("fw_in_ready_empty", 32'(bus.in_ready), 1);
        end

        // Overflow: 8'hEE is dropped
        fill_16('h10);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hEE;
        tick();
        bus.in_valid = 1'b0;
        chk("ov_flag", 32'(bus.overflow), 1);
        chk("ov_fill", 32'(bus.fill_level), 16);
        chk("ov_head", 32'(bus.out_data), 'h10);
`ifdef JTAG_BYTE_FIFO_STATS_EN
        chk("ov_drop_count", 32'(bus.drop_count), 1);
`endif
        tick();
        chk("ov_sticky", 32'(bus.overflow), 1);
        bus.clear_overflow = 1'b1;
        tick();
        bus.clear_overflow = 1'b0;
        chk("ov_cleared", 32'(bus.overflow), 0);
`ifdef JTAG_BYTE_FIFO_STATS_EN
        chk("ov_count_cleared", 32'(bus.drop_count), 0);
`endif

        // Full with pop: 8'h55 is accepted, head 8'h10 leaves
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h55;
        tick();
        bus.in_valid  = 1'b0;
        chk("fp_fill", 32'(bus.fill_level), 16);
        chk("fp_overflow", 32'(bus.overflow), 0);
        for (int i = 0; i < 15; i++) begin
            chk("fp_drain_data", 32'(bus.out_data), 32'('h11 + i));
            tick();
        end
        chk("fp_last_valid", 32'(bus.out_valid), 1);
        chk("fp_last_data", 32'(bus.out_data), 'h55);
        tick();
        chk("fp_empty", 32'(bus.fill_level), 0);

        // Two drops, then clear collides with a third drop
        fill_16('h20);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hEE;
        tick();
        tick();
        bus.clear_overflow = 1'b1;
        tick();
        bus.clear_overflow = 1'b0;
        bus.in_valid       = 1'b0;
        chk("cd_overflow", 32'(bus.overflow), 1);
        chk("cd_fill", 32'(bus.fill_level), 16);
`ifdef JTAG_BYTE_FIFO_STATS_EN
        chk("cd_drop_count", 32'(bus.drop_count), 1);
`endif
        bus.clear_overflow = 1'b1;
        tick();
        bus.clear_overflow = 1'b0;
        chk("cd_cleared", 32'(bus.overflow), 0);

        // Mid-stream reset with 7 stored bytes
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'('h30 + i);
            tick();
        end
        bus.in_valid = 1'b0;
        chk("mr_fill7", 32'(bus.fill_level), 7);
        reset = 1'b1;
        tick();
        chk("mr_fill0", 32'(bus.fill_level), 0);
        chk("mr_valid0", 32'(bus.out_valid), 0);
        reset        = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h77;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("mr_new_data", 32'(bus.out_data), 'h77);
        chk("mr_new_fill", 32'(bus.fill_level), 1);
        tick();
        chk("mr_final_empty", 32'(bus.out_valid), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
